// File: rtl/axis_result_packer.sv
// Serializes one wide PE result word into BEATS narrow AXI-Stream beats, LSB slice first,
// and marks the last beat of every FRAME_RESULTS-th result with tlast.
module axis_result_packer #(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int FRAME_RESULTS = 16,
  localparam int IN_WIDTH     = (DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE) * KERNEL_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [BUS_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy
);

  localparam int BEATS  = (IN_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int HOLD_W = BEATS * BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RES_W  = (FRAME_RESULTS > 1) ? $clog2(FRAME_RESULTS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic [RES_W-1:0]    r_res, w_res_nxt;
  // Held word is zero-extended to a whole number of beats so the top slice is padded.
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;

  logic                w_send;
  logic                w_last_beat;
  logic                w_res_last;
  logic [BUS_WIDTH-1:0] w_slice;

  assign w_send      = (r_state == ST_SEND);
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_res_last  = (r_res == RES_W'(FRAME_RESULTS - 1));

  // Select the beat slice currently presented on the output.
  always_comb begin
    w_slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BEAT_W'(b)) w_slice = r_hold[b*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Output decode; s_axis_tready passes m_axis_tready through on the last beat so a new
  // word can load in the same cycle the previous one finishes.
  always_comb begin
    busy          = w_send;
    m_axis_tvalid = w_send;
    m_axis_tdata  = w_send ? w_slice : '0;
    m_axis_tlast  = w_send & w_last_beat & w_res_last;
    s_axis_tready = ~rst & (~w_send | (w_last_beat & m_axis_tready));
  end

  // Next-state logic for FSM, beat counter, frame result counter and hold register.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_res_nxt   = r_res;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          w_hold_nxt  = HOLD_W'(s_axis_tdata);
          w_beat_nxt  = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          if (w_last_beat) begin
            w_beat_nxt = '0;
            w_res_nxt  = w_res_last ? '0 : r_res + RES_W'(1);
            if (s_axis_tvalid) begin
              w_hold_nxt = HOLD_W'(s_axis_tdata);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_res   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_res   <= w_res_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

endmodule

// File: tb/tb_axis_result_packer.sv
// Directed bench for axis_result_packer: default instance plus a FRAME_RESULTS=1 instance.
module tb_axis_result_packer;

  logic        clk;
  logic        rst;

  logic [56:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, busy;

  logic [56:0] s1_tdata;
  logic        s1_tvalid, s1_tready;
  logic [31:0] m1_tdata;
  logic        m1_tvalid, m1_tready, m1_tlast, busy1;

  int n_checks = 0;
  int n_errors = 0;

  axis_result_packer u_dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .busy          (busy)
  );

  axis_result_packer #(.FRAME_RESULTS(1)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s1_tdata),
    .s_axis_tvalid (s1_tvalid),
    .s_axis_tready (s1_tready),
    .m_axis_tdata  (m1_tdata),
    .m_axis_tvalid (m1_tvalid),
    .m_axis_tready (m1_tready),
    .m_axis_tlast  (m1_tlast),
    .busy          (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated result with m_tready=1; checks both beats and tlast on the second.
  task automatic send_single(input logic [56:0] d, input logic exp_last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    #1;
    check("single_b0", m_tdata, d[31:0]);
    check("single_b0_last", m_tlast, 1'b0);
    step();
    #1;
    check("single_b1", m_tdata, {7'd0, d[56:32]});
    check("single_b1_last", m_tlast, exp_last);
    step();
  endtask

  function automatic logic [56:0] word_k(input int k);
    logic [24:0] hi;
    logic [31:0] lo;
    hi = 25'(k * 3 + 1);
    lo = 32'hA000_0000 | 32'(k);
    return {hi, lo};
  endfunction

  logic [56:0] d1, d2, d3, wexp;

  initial begin
    d1 = 57'h1_2345_6789_ABCD_EF;
    d2 = 57'h1A5A5A5_3C3C3C3C;
    d3 = 57'h0F0F0F0_55555555;
    rst = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    s1_tdata = '0; s1_tvalid = 1'b0; m1_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_s_tready", s_tready, 1'b1);

    // Single result, m_tready=1
    step();
    s_tvalid = 1'b1; s_tdata = d1; m_tready = 1'b1;
    #1;
    check("a_idle_tready", s_tready, 1'b1);
    check("a_idle_tvalid", m_tvalid, 1'b0);
    step();
    s_tvalid = 1'b0;
    #1;
    check("a_b0_valid", m_tvalid, 1'b1);
    check("a_b0_data", m_tdata, 32'h89ABCDEF);
    check("a_b0_last", m_tlast, 1'b0);
    check("a_b0_busy", busy, 1'b1);
    check("a_b0_s_tready", s_tready, 1'b0);
    step();
    #1;
    check("a_b1_data", m_tdata, 32'h01234567);
    check("a_b1_last", m_tlast, 1'b0);
    check("a_b1_s_tready", s_tready, 1'b1);
    step();
    #1;
    check("a_idle_busy", busy, 1'b0);
    check("a_idle_valid", m_tvalid, 1'b0);

    // s_tvalid held with m_tready=0: only the first word is captured
    s_tvalid = 1'b1; s_tdata = d2; m_tready = 1'b0;
    #1;
    check("b_idle_tready", s_tready, 1'b1);
    step();
    s_tdata = d3;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("b_stall_s_tready", s_tready, 1'b0);
      check("b_stall_valid", m_tvalid, 1'b1);
      check("b_stall_data", m_tdata, 32'h3C3C3C3C);
      check("b_stall_last", m_tlast, 1'b0);
      step();
    end
    // m_tready toggling: no beat lost or duplicated
    s_tvalid = 1'b0; m_tready = 1'b1;
    #1;
    check("b_t0_data", m_tdata, 32'h3C3C3C3C);
    step();
    m_tready = 1'b0;
    #1;
    check("b_t1_data", m_tdata, 32'h01A5A5A5);
    check("b_t1_s_tready", s_tready, 1'b0);
    step();
    m_tready = 1'b1;
    #1;
    check("b_t2_data", m_tdata, 32'h01A5A5A5);
    check("b_t2_last", m_tlast, 1'b0);
    check("b_t2_s_tready", s_tready, 1'b1);
    step();
    m_tready = 1'b0;
    #1;
    check("b_done_busy", busy, 1'b0);
    check("b_done_valid", m_tvalid, 1'b0);

    // New frame: results 0..4, then reset in the middle of result 5
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) send_single(word_k(k), 1'b0);
    s_tvalid = 1'b1; s_tdata = word_k(5); m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    step();
    #1;
    check("c_pre_rst_data", m_tdata, {7'd0, word_k(5)[56:32]});
    rst = 1'b1;
    #1;
    check("c_rst_valid", m_tvalid, 1'b0);
    check("c_rst_data", m_tdata, 32'd0);
    check("c_rst_last", m_tlast, 1'b0);
    check("c_rst_busy", busy, 1'b0);
    check("c_rst_s_tready", s_tready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("c_rel_s_tready", s_tready, 1'b1);

    // 32 back-to-back results: 64 gapless beats, tlast on beats 32 and 64
    s_tvalid = 1'b1; s_tdata = word_k(0); m_tready = 1'b1;
    step();
    for (int c = 0; c < 64; c++) begin
      s_tvalid = ((c / 2) + 1) < 32;
      s_tdata  = word_k((c / 2) + 1);
      wexp     = word_k(c / 2);
      #1;
      check("d_valid", m_tvalid, 1'b1);
      check("d_data", m_tdata, (c % 2 == 0) ? {32'd0, wexp[31:0]} : {39'd0, wexp[56:32]});
      check("d_last", m_tlast, (c == 31) || (c == 63));
      check("d_s_tready", s_tready, (c % 2) == 1);
      step();
    end
    s_tvalid = 1'b0;
    #1;
    check("d_done_busy", busy, 1'b0);

    // FRAME_RESULTS=1: tlast on every second beat
    s1_tvalid = 1'b1; s1_tdata = d1;
    step();
    for (int c = 0; c < 6; c++) begin
      s1_tvalid = (c / 2) < 2;
      #1;
      check("e_valid", m1_tvalid, 1'b1);
      check("e_data", m1_tdata, (c % 2 == 0) ? 32'h89ABCDEF : 32'h01234567);
      check("e_last", m1_tlast, (c % 2) == 1);
      step();
    end
    s1_tvalid = 1'b0;
    #1;
    check("e_done_busy", busy1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
